// File: rtl/occupancy_grid_rmw.sv
// occupancy_grid_rmw: pipelined saturating log-odds read-modify-write engine with clear sweep and map read port.
// Build option: define OCCUPANCY_FORWARD_EN to forward the last write instead of stalling same-cell accesses.
module occupancy_grid_rmw #(
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 7,
  parameter int CELL_WIDTH = 8,
  parameter int HIT_INC    = 1,
  parameter int MISS_DEC   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [X_WIDTH-1:0]    upd_x,
  input  logic [Y_WIDTH-1:0]    upd_y,
  input  logic                  upd_hit,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  input  logic [X_WIDTH-1:0]    rd_x,
  input  logic [Y_WIDTH-1:0]    rd_y,
  output logic                  rd_data_valid,
  output logic [CELL_WIDTH-1:0] rd_data
);
  localparam int AW    = X_WIDTH + Y_WIDTH;
  localparam int DEPTH = 2 ** AW;
  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic signed [CELL_WIDTH:0] CMAX  = (CELL_WIDTH+1)'(2 ** (CELL_WIDTH-1) - 1);
  localparam logic signed [CELL_WIDTH:0] CMIN  = (CELL_WIDTH+1)'(1 - 2 ** (CELL_WIDTH-1));
  localparam logic signed [CELL_WIDTH:0] INC_H = (CELL_WIDTH+1)'(HIT_INC);
  localparam logic signed [CELL_WIDTH:0] INC_M = (CELL_WIDTH+1)'(-MISS_DEC);
  localparam logic [CELL_WIDTH-1:0] CMAX_C = CELL_WIDTH'(2 ** (CELL_WIDTH-1) - 1);
  localparam logic [CELL_WIDTH-1:0] CMIN_C = CELL_WIDTH'(1 - 2 ** (CELL_WIDTH-1));

  logic [1:0]            state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic                  s1_v_q, s1_h_q, rdv_q;
  logic [AW-1:0]         s1_a_q;
  logic [AW-1:0]         ua, ra_rd, ra, wa;
  logic                  run, acc, haz_u, haz_r, we;
  logic [CELL_WIDTH-1:0] mem [DEPTH];
  logic [CELL_WIDTH-1:0] dout, old, rd_val, nxt, wd;
  logic signed [CELL_WIDTH:0] old_x, sum;

  assign ua    = {upd_y, upd_x};
  assign ra_rd = {rd_y, rd_x};
  // the done cycle still blocks traffic so the map is only touched after the pulse
  assign run       = (state_q == S_RUN) && !done_q;
  assign upd_ready = run && !haz_u;
  assign acc       = upd_valid && upd_ready;
  assign rd_gnt    = rd_req && run && !acc && !haz_r;
  assign ra        = acc ? ua : ra_rd;

  assign old_x = {old[CELL_WIDTH-1], old};
  assign sum   = old_x + (s1_h_q ? INC_H : INC_M);
  assign nxt   = sum > CMAX ? CMAX_C : (sum < CMIN ? CMIN_C : sum[CELL_WIDTH-1:0]);

  assign we = busy_q || s1_v_q;
  assign wa = busy_q ? cnt_q : s1_a_q;
  assign wd = busy_q ? '0 : nxt;

  assign clear_busy    = busy_q;
  assign clear_done    = done_q;
  assign rd_data_valid = rdv_q;
  assign rd_data       = rdv_q ? rd_val : '0;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      busy_d = 1'b1;
      if (busy_q) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_RUN;
        end
      end
    end else if (state_q == S_DRAIN) begin
      if (!s1_v_q) begin
        state_d = S_CLEAR;
        busy_d  = 1'b1;
      end
    end else if (clear_start) begin
      state_d = S_DRAIN;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_CLEAR;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_h_q  <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      s1_v_q  <= acc;
      s1_a_q  <= ua;
      s1_h_q  <= upd_hit;
      rdv_q   <= rd_gnt;
    end
  end

  // read-during-write returns the old word; contents are only zeroed by the sweep
  always_ff @(posedge clock) begin
    if (we) mem[wa] <= wd;
    dout <= mem[ra];
  end

`ifdef OCCUPANCY_FORWARD_EN
  logic                  lwr_v_q;
  logic [AW-1:0]         lwr_a_q, rd_a_q;
  logic [CELL_WIDTH-1:0] lwr_d_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lwr_v_q <= 1'b0;
      lwr_a_q <= '0;
      lwr_d_q <= '0;
      rd_a_q  <= '0;
    end else begin
      rd_a_q <= ra_rd;
      if (busy_q) lwr_v_q <= 1'b0;
      else if (s1_v_q) begin
        lwr_v_q <= 1'b1;
        lwr_a_q <= s1_a_q;
        lwr_d_q <= nxt;
      end
    end
  end

  assign haz_u  = 1'b0;
  assign haz_r  = 1'b0;
  assign old    = (lwr_v_q && lwr_a_q == s1_a_q) ? lwr_d_q : dout;
  assign rd_val = (lwr_v_q && lwr_a_q == rd_a_q) ? lwr_d_q : dout;
`else
  assign haz_u  = s1_v_q && (s1_a_q == ua);
  assign haz_r  = s1_v_q && (s1_a_q == ra_rd);
  assign old    = dout;
  assign rd_val = dout;
`endif
endmodule

// File: tb/tb_occupancy_grid_rmw.sv
// tb_occupancy_grid_rmw: directed self-checking bench on a 32x16 grid of 8-bit cells.
module tb_occupancy_grid_rmw;
`ifdef OCCUPANCY_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int DEPTH = 512;

  logic clock = 1'b0, reset_n = 1'b0, clear_start = 1'b0;
  logic clear_busy, clear_done, upd_ready, rd_gnt, rd_data_valid;
  logic upd_valid = 1'b0, upd_hit = 1'b0, rd_req = 1'b0;
  logic [4:0] upd_x = '0, rd_x = '0;
  logic [3:0] upd_y = '0, rd_y = '0;
  logic signed [7:0] rd_data;
  int total = 0, bad = 0;

  occupancy_grid_rmw #(.X_WIDTH(5), .Y_WIDTH(4), .CELL_WIDTH(8), .HIT_INC(1), .MISS_DEC(1)) dut (
    .clock(clock), .reset_n(reset_n), .clear_start(clear_start), .clear_busy(clear_busy),
    .clear_done(clear_done), .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_x(upd_x),
    .upd_y(upd_y), .upd_hit(upd_hit), .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_x(rd_x),
    .rd_y(rd_y), .rd_data_valid(rd_data_valid), .rd_data(rd_data)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Inputs change at posedge+1, outputs are sampled at negedge; tasks return at posedge+1.
  task automatic send_upd(input int x, input int y, input bit hit);
    bit r = 1'b0;
    upd_x = 5'(x); upd_y = 4'(y); upd_hit = hit; upd_valid = 1'b1;
    for (int n = 0; n < 20 && !r; n++) begin
      @(negedge clock); r = upd_ready;
      @(posedge clock); #1;
    end
    upd_valid = 1'b0;
    if (!r) begin total++; bad++; $display("FAIL upd_timeout (%0d,%0d) never accepted", x, y); end
  endtask

  task automatic do_read(input int x, input int y, output logic signed [7:0] d, output bit ok);
    bit g = 1'b0;
    rd_x = 5'(x); rd_y = 4'(y); rd_req = 1'b1;
    for (int n = 0; n < 20 && !g; n++) begin
      @(negedge clock); g = rd_gnt;
      @(posedge clock); #1;
    end
    rd_req = 1'b0;
    @(negedge clock); ok = g && rd_data_valid; d = rd_data;
    @(posedge clock); #1;
  endtask

  task automatic run_sweep(output int busy_n, output int done_n, output int traffic_n, output bit tmo);
    busy_n = 0; done_n = 0; traffic_n = 0; tmo = 1'b1;
    for (int n = 0; n < 2 * DEPTH; n++) begin
      @(negedge clock);
      if (clear_busy) busy_n++;
      if (upd_ready || rd_gnt) traffic_n++;
      if (clear_done) begin done_n++; tmo = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    int b, dn, t; bit tmo, ok; logic signed [7:0] d;
    #12;
    total++;
    if ({clear_busy, clear_done, upd_ready, rd_data_valid} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {clear_busy, clear_done, upd_ready, rd_data_valid});
    end
    total++; if (rd_data !== 8'sd0) begin bad++; $display("FAIL reset_rd_data got=%0d want=0", rd_data); end
    @(posedge clock); #1; reset_n = 1'b1;
    run_sweep(b, dn, t, tmo);
    total++; if (tmo || b != DEPTH) begin bad++; $display("FAIL clear_len got=%0d want=%0d tmo=%0b", b, DEPTH, tmo); end
    total++; if (dn != 1) begin bad++; $display("FAIL clear_done_count got=%0d want=1", dn); end
    total++; if (t != 0) begin bad++; $display("FAIL ready_in_clear got=%0d want=0", t); end
    @(posedge clock); #1;
    @(negedge clock);
    total++; if (upd_ready !== 1'b1 || clear_done !== 1'b0) begin
      bad++; $display("FAIL post_clear ready=%b done=%b want ready=1 done=0", upd_ready, clear_done);
    end
    @(posedge clock); #1;
    do_read(0, 0, d, ok);
    total++; if (!ok || d !== 8'sd0) begin bad++; $display("FAIL rd_0_0 got=%0d ok=%0b want=0", d, ok); end
    @(negedge clock);
    total++; if (rd_data_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_one_cycle got=%b want=0", rd_data_valid); end
    @(posedge clock); #1;
    do_read(31, 15, d, ok);
    total++; if (!ok || d !== 8'sd0) begin bad++; $display("FAIL rd_31_15 got=%0d ok=%0b want=0", d, ok); end
  endtask

  task automatic test_saturation;
    bit ok; logic signed [7:0] d;
    for (int i = 0; i < 127; i++) send_upd(5, 3, 1'b1);
    do_read(5, 3, d, ok);
    total++; if (!ok || d !== 8'sd127) begin bad++; $display("FAIL hit127 got=%0d ok=%0b want=127", d, ok); end
    for (int i = 0; i < 73; i++) send_upd(5, 3, 1'b1);
    do_read(5, 3, d, ok);
    total++; if (!ok || d !== 8'sd127) begin bad++; $display("FAIL hit200_sat got=%0d ok=%0b want=127", d, ok); end
    for (int i = 0; i < 100; i++) send_upd(5, 3, 1'b0);
    do_read(5, 3, d, ok);
    total++; if (!ok || d !== 8'sd27) begin bad++; $display("FAIL miss100 got=%0d ok=%0b want=27", d, ok); end
    for (int i = 0; i < 200; i++) send_upd(5, 3, 1'b0);
    do_read(5, 3, d, ok);
    total++; if (!ok || d !== -8'sd127) begin bad++; $display("FAIL miss300_sat got=%0d ok=%0b want=-127", d, ok); end
    send_upd(7, 7, 1'b0);
    do_read(7, 7, d, ok);
    total++; if (!ok || d !== -8'sd1) begin bad++; $display("FAIL single_miss got=%0d ok=%0b want=-1", d, ok); end
  endtask

  task automatic test_back_to_back;
    bit ok, r, e; logic signed [7:0] d;
    upd_x = 5'd10; upd_y = 4'd10; upd_hit = 1'b1; upd_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock); r = upd_ready; e = FWD || (i % 2 == 0);
      total++; if (r !== e) begin bad++; $display("FAIL same_cell_ready[%0d] got=%b want=%b", i, r, e); end
      @(posedge clock); #1;
    end
    upd_valid = 1'b0;
    do_read(10, 10, d, ok);
    e = FWD;
    total++; if (!ok || d !== (e ? 8'sd16 : 8'sd8)) begin
      bad++; $display("FAIL same_cell_value got=%0d ok=%0b want=%0d", d, ok, e ? 16 : 8);
    end
    upd_y = 4'd1; upd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      upd_x = (i % 2 == 0) ? 5'd20 : 5'd21;
      @(negedge clock);
      total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL diff_cell_ready[%0d] got=%b want=1", i, upd_ready); end
      @(posedge clock); #1;
    end
    upd_valid = 1'b0;
    do_read(20, 1, d, ok);
    total++; if (!ok || d !== 8'sd5) begin bad++; $display("FAIL alt_cell20 got=%0d ok=%0b want=5", d, ok); end
    do_read(21, 1, d, ok);
    total++; if (!ok || d !== 8'sd5) begin bad++; $display("FAIL alt_cell21 got=%0d ok=%0b want=5", d, ok); end
  endtask

  task automatic test_rd_vs_upd;
    bit g;
    rd_x = 5'd14; rd_y = 4'd2; rd_req = 1'b1;
    upd_y = 4'd2; upd_hit = 1'b1; upd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      upd_x = 5'(12 + i);
      @(negedge clock);
      total++; if (rd_gnt !== 1'b0) begin bad++; $display("FAIL rd_blocked[%0d] got=%b want=0", i, rd_gnt); end
      @(posedge clock); #1;
    end
    upd_valid = 1'b0;
    @(negedge clock); g = rd_gnt;
    total++; if (g !== FWD) begin bad++; $display("FAIL rd_gnt_after_upd got=%b want=%b", g, FWD); end
    if (!g) begin
      @(posedge clock); #1;
      @(negedge clock);
      total++; if (rd_gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt_after_bubble got=%b want=1", rd_gnt); end
    end
    @(posedge clock); #1; rd_req = 1'b0;
    @(negedge clock);
    total++; if (rd_data_valid !== 1'b1 || rd_data !== 8'sd1) begin
      bad++; $display("FAIL rd_after_upd got=%0d valid=%b want=1", rd_data, rd_data_valid);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_clear_drain;
    int b, dn, t; bit tmo, ok; logic signed [7:0] d;
    upd_x = 5'd9; upd_y = 4'd9; upd_hit = 1'b1; upd_valid = 1'b1; clear_start = 1'b1;
    @(negedge clock);
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL drain_accept got=%b want=1", upd_ready); end
    @(posedge clock); #1;
    upd_valid = 1'b0; clear_start = 1'b0; rd_x = 5'd9; rd_y = 4'd9; rd_req = 1'b1;
    @(negedge clock);
    total++; if ({upd_ready, rd_gnt, clear_busy} !== 3'b000) begin
      bad++; $display("FAIL drain_hold got=%b want=000", {upd_ready, rd_gnt, clear_busy});
    end
    @(posedge clock); #1; clear_start = 1'b1;
    @(negedge clock);
    total++; if ({upd_ready, rd_gnt} !== 2'b00) begin bad++; $display("FAIL drain_hold2 got=%b want=00", {upd_ready, rd_gnt}); end
    @(posedge clock); #1; clear_start = 1'b0;
    run_sweep(b, dn, t, tmo);
    total++; if (tmo || b != DEPTH) begin bad++; $display("FAIL reclear_len got=%0d want=%0d tmo=%0b", b, DEPTH, tmo); end
    total++; if (t != 0) begin bad++; $display("FAIL traffic_in_clear got=%0d want=0", t); end
    @(posedge clock); #1;
    @(negedge clock);
    total++; if ({upd_ready, rd_gnt} !== 2'b11) begin bad++; $display("FAIL after_reclear got=%b want=11", {upd_ready, rd_gnt}); end
    @(posedge clock); #1; rd_req = 1'b0;
    @(negedge clock);
    total++; if (rd_data_valid !== 1'b1 || rd_data !== 8'sd0) begin
      bad++; $display("FAIL drained_cell got=%0d valid=%b want=0", rd_data, rd_data_valid);
    end
    @(posedge clock); #1;
    do_read(5, 3, d, ok);
    total++; if (!ok || d !== 8'sd0) begin bad++; $display("FAIL cleared_5_3 got=%0d ok=%0b want=0", d, ok); end
  endtask

  task automatic test_reset_mid_sweep;
    int b, dn, t, n; bit tmo, ok; logic signed [7:0] d;
    send_upd(4, 4, 1'b1);
    do_read(4, 4, d, ok);
    total++; if (!ok || d !== 8'sd1) begin bad++; $display("FAIL pre_reset_cell got=%0d ok=%0b want=1", d, ok); end
    clear_start = 1'b1;
    @(posedge clock); #1; clear_start = 1'b0;
    n = 0;
    for (int i = 0; i < 2 * DEPTH && n < 300; i++) begin
      @(negedge clock); if (clear_busy) n++;
    end
    total++; if (n != 300) begin bad++; $display("FAIL sweep_progress got=%0d want=300", n); end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({clear_busy, clear_done, upd_ready, rd_data_valid} !== 4'b0 || rd_data !== 8'sd0) begin
      bad++; $display("FAIL midsweep_reset flags=%b data=%0d want 0", {clear_busy, clear_done, upd_ready, rd_data_valid}, rd_data);
    end
    @(posedge clock); @(posedge clock); #1; reset_n = 1'b1;
    run_sweep(b, dn, t, tmo);
    total++; if (tmo || b != DEPTH || dn != 1) begin
      bad++; $display("FAIL restart_sweep got=%0d done=%0d want=%0d done=1", b, dn, DEPTH);
    end
    @(posedge clock); #1;
    do_read(4, 4, d, ok);
    total++; if (!ok || d !== 8'sd0) begin bad++; $display("FAIL post_reset_cell got=%0d ok=%0b want=0", d, ok); end
  endtask

  initial begin
    test_reset;
    test_saturation;
    test_back_to_back;
    test_rd_vs_upd;
    test_clear_drain;
    test_reset_mid_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
